// File: rtl/dart_pkg.sv
// Shared types and helpers for the dart launch arbiter and its neighbours.
package dart_pkg;

    typedef logic [19:0] coord_t;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        LAUNCH = 3'd2,
        FLIGHT = 3'd3,
        RETIRE = 3'd4
    } arb_state_t;

    function automatic logic [9:0] coord_x(input coord_t c);
        return c[19:10];
    endfunction

    function automatic logic [9:0] coord_y(input coord_t c);
        return c[9:0];
    endfunction

endpackage

// File: rtl/dart_launch_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] eligible,
    input  logic [2:0]   ptr,
    output logic [N-1:0] onehot,
    output logic [2:0]   idx,
    output logic         any
);

    int unsigned j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any && eligible[j]) begin
                onehot[j] = 1'b1;
                idx       = 3'(j);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dart_launch_arbiter.sv
// Round-robin owner of the single dart-flight datapath: grant, settle, launch,
// monitor flight, retire, with per-monkey cooldown.
module dart_launch_arbiter
    import dart_pkg::*;
#(
    parameter int unsigned N_MONK    = 4,
    parameter int unsigned SETUP_CYC = 3,
    parameter int unsigned COOLDOWN  = 50000000,
    parameter int unsigned TIMEOUT   = 100000000,
    parameter int unsigned X_MAX     = SCREEN_W,
    parameter int unsigned Y_MAX     = SCREEN_H
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic [N_MONK-1:0]    req_valid,
    input  logic [20*N_MONK-1:0] req_start,
    input  logic [20*N_MONK-1:0] req_dest,
    input  logic [19:0]          dart_pos,
    output logic [19:0]          dart_start,
    output logic [19:0]          dart_dest,
    output logic                 monk_ready,
    output logic                 dart_kill,
    output logic [N_MONK-1:0]    grant,
    output logic [2:0]           active_id,
    output logic                 busy,
    output logic                 hit,
    output logic                 miss
);

    localparam int unsigned CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int unsigned FC_W = ($clog2(TIMEOUT + 1) > 2) ? $clog2(TIMEOUT + 1) : 2;
    localparam int unsigned SC_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    arb_state_t        state;
    logic [2:0]        ptr;
    logic [N_MONK-1:0] elig;
    logic [N_MONK-1:0] pick_oh;
    logic [2:0]        pick_idx;
    logic              pick_any;
    coord_t            start_r;
    coord_t            dest_r;
    logic [2:0]        id_r;
    logic [SC_W-1:0]   setup_cnt;
    logic [FC_W-1:0]   flight_cnt;
    logic [FC_W-1:0]   fc_next;
    logic              hit_r;
    logic              pos_hit, pos_oob, pos_lost, timed_out, flight_exit;

    function automatic logic in_bounds(input coord_t c);
        return (32'(coord_x(c)) < X_MAX) && (32'(coord_y(c)) < Y_MAX);
    endfunction

    for (genvar i = 0; i < N_MONK; i++) begin : g_monk
        coord_t          s;
        coord_t          d;
        logic [CD_W-1:0] cooldown;

        assign s = req_start[20*i +: 20];
        assign d = req_dest[20*i +: 20];
        assign elig[i] = req_valid[i] && (cooldown == '0) && (s != '0)
                         && in_bounds(d) && (d != s);

        // Retire load takes precedence over the running decrement.
        always_ff @(posedge Clk) begin
            if (reset)
                cooldown <= '0;
            else if (state == RETIRE && id_r == 3'(i))
                cooldown <= CD_W'(COOLDOWN);
            else if (cooldown != '0)
                cooldown <= cooldown - CD_W'(1);
        end
    end

    rr_pick #(.N(N_MONK)) u_pick (
        .eligible (elig),
        .ptr      (ptr),
        .onehot   (pick_oh),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        fc_next     = flight_cnt + FC_W'(1);
        pos_hit     = (dart_pos == dest_r);
        pos_oob     = (dart_pos != '0) && !in_bounds(dart_pos);
        pos_lost    = (dart_pos == '0) && (flight_cnt >= FC_W'(2));
        timed_out   = (fc_next == FC_W'(TIMEOUT - 1));
        flight_exit = pos_hit || pos_oob || pos_lost || timed_out;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            start_r    <= '0;
            dest_r     <= '0;
            id_r       <= '0;
            setup_cnt  <= '0;
            flight_cnt <= '0;
            hit_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        start_r   <= req_start[20*pick_idx +: 20];
                        dest_r    <= req_dest[20*pick_idx +: 20];
                        id_r      <= pick_idx;
                        ptr       <= (32'(pick_idx) >= N_MONK - 1) ? 3'd0 : pick_idx + 3'd1;
                        setup_cnt <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt == SC_W'(SETUP_CYC - 1))
                        state <= LAUNCH;
                    else
                        setup_cnt <= setup_cnt + SC_W'(1);
                end
                LAUNCH: begin
                    flight_cnt <= '0;
                    state      <= FLIGHT;
                end
                FLIGHT: begin
                    flight_cnt <= fc_next;
                    if (flight_exit) begin
                        hit_r <= pos_hit;
                        state <= RETIRE;
                    end
                end
                RETIRE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Grant-cycle outputs come straight from the picker so they appear in IDLE.
    assign grant      = (!reset && state == IDLE) ? pick_oh : '0;
    assign busy       = !reset && (state != IDLE || pick_any);
    assign active_id  = reset ? 3'd0 : (state == IDLE) ? (pick_any ? pick_idx : 3'd0) : id_r;
    assign dart_start = reset ? '0 : start_r;
    assign dart_dest  = reset ? '0 : dest_r;
    assign monk_ready = !reset && state == LAUNCH;
    assign dart_kill  = !reset && state == RETIRE;
    assign hit        = dart_kill && hit_r;
    assign miss       = dart_kill && !hit_r;

endmodule

// File: tb/tb_dart_launch_arbiter.sv
// Scoreboard bench for dart_launch_arbiter with a small behavioural dart datapath.
module tb_dart_launch_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned SC = 3;
    localparam int unsigned CD = 20;
    localparam int unsigned TO = 50;

    localparam int K_GRANT = 0, K_HIT = 1, K_MISS = 2;
    localparam int M_HIT = 0, M_OOB = 1, M_FROZEN = 2, M_LOST = 3;

    logic           Clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [20*N-1:0] req_start = '0;
    logic [20*N-1:0] req_dest = '0;
    logic [19:0]    dart_pos = '0;
    logic [19:0]    dart_start, dart_dest;
    logic           monk_ready, dart_kill, busy, hit, miss;
    logic [N-1:0]   grant;
    logic [2:0]     active_id;

    dart_launch_arbiter #(
        .N_MONK(N), .SETUP_CYC(SC), .COOLDOWN(CD), .TIMEOUT(TO), .X_MAX(640), .Y_MAX(480)
    ) dut (
        .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_start(req_start),
        .req_dest(req_dest), .dart_pos(dart_pos), .dart_start(dart_start),
        .dart_dest(dart_dest), .monk_ready(monk_ready), .dart_kill(dart_kill),
        .grant(grant), .active_id(active_id), .busy(busy), .hit(hit), .miss(miss)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          kind;
        int          id;
        int          lat;
        logic [19:0] st;
        logic [19:0] ds;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0, n_bad = 0;
    int          n_grants = 0;
    longint      cyc = 0, g_cyc = 0, l_cyc = 0, r_cyc = 0;
    logic [19:0] cur_s = '0, cur_d = '0;
    int          mode = M_HIT, hit_k = 9, fk = 0, rr_ptr = 0;
    bit          flying = 0;
    logic [19:0] m_start = '0, m_dest = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [19:0] xy(input int x, input int y);
        return {10'(x), 10'(y)};
    endfunction

    task automatic set_req(input int i, input logic [19:0] s, input logic [19:0] d);
        req_start[20*i +: 20] = s;
        req_dest[20*i +: 20]  = d;
    endtask

    task automatic push(input int kind, input int id, input int lat,
                        input logic [19:0] s, input logic [19:0] d);
        exp_t e;
        e.kind = kind; e.id = id; e.lat = lat; e.st = s; e.ds = d;
        sb.push_back(e);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(posedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_val("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge Clk);
        #2;
    endtask

    task automatic wait_grants(input int target, input int max_cyc);
        int n = 0;
        while (n_grants < target && n < max_cyc) begin
            @(posedge Clk);
            n++;
        end
        check_val("grant_wait", n_grants >= target, 1);
        @(posedge Clk);
        #2;
    endtask

    // Datapath model: reacts to monk_ready/dart_kill a little after each edge.
    initial begin
        forever begin
            @(posedge Clk);
            #2;
            if (reset || dart_kill) begin
                flying   = 0;
                dart_pos = '0;
            end else begin
                if (monk_ready) begin
                    flying = 1;
                    fk     = 0;
                end else if (flying) begin
                    fk++;
                end
                if (flying) begin
                    case (mode)
                        M_HIT:    dart_pos = (fk >= hit_k) ? m_dest : m_start;
                        M_OOB:    dart_pos = (fk >= 4) ? xy(650, 100) : m_start;
                        M_FROZEN: dart_pos = xy(150, 150);
                        default:  dart_pos = '0;
                    endcase
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every grant and every retire.
    always @(negedge Clk) begin
        exp_t e;
        if (!reset) begin
            if (grant != '0) begin
                if (sb.size() == 0 || sb[0].kind != K_GRANT) begin
                    check_val("unexp_grant", grant, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("grant", grant, 64'(1) << e.id);
                    check_val("active_id", active_id, e.id);
                    check_val("busy_at_grant", busy, 1);
                    if (e.lat >= 0) check_val("cooldown_gap", cyc - r_cyc, e.lat);
                    cur_s = e.st;
                    cur_d = e.ds;
                    n_grants++;
                end
                g_cyc = cyc;
            end
            if (monk_ready) begin
                check_val("launch_lat", cyc - g_cyc, SC + 1);
                check_val("dart_start", dart_start, cur_s);
                check_val("dart_dest", dart_dest, cur_d);
                check_val("busy_at_launch", busy, 1);
                l_cyc = cyc;
            end
            if (dart_kill || hit || miss) begin
                if (sb.size() == 0 || sb[0].kind == K_GRANT) begin
                    check_val("unexp_retire", {dart_kill, hit, miss}, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("outcome", {dart_kill, hit, miss},
                              (e.kind == K_HIT) ? 3'b110 : 3'b101);
                    if (e.lat >= 0) check_val("flight_lat", cyc - l_cyc, e.lat);
                end
                r_cyc = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t reached, scoreboard depth %0d expected 0", $time, sb.size());
        $fatal(1);
    end

    initial begin
        // Reset with every monkey requesting; first IDLE cycle grants monkey 0.
        for (int i = 0; i < int'(N); i++) set_req(i, xy(10 + i*100, 20), xy(30 + i*100, 400));
        req_valid = '1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_val("reset_outputs",
                  {dart_start, dart_dest, monk_ready, dart_kill, grant, active_id, busy, hit, miss}, 0);
        mode = M_HIT; m_start = xy(10, 20); m_dest = xy(30, 400);
        push(K_GRANT, 0, -1, m_start, m_dest);
        push(K_HIT, 0, hit_k + 1, 0, 0);
        @(posedge Clk); #2;
        reset = 1'b0;
        @(negedge Clk);
        check_val("first_grant", grant, 4'b0001);
        @(posedge Clk); #2;
        req_valid = '0;
        set_req(0, xy(5, 5), xy(6, 6));
        drain(200);
        rr_ptr = 1;

        // Monkey 2 hits, then re-requests and must wait out its cooldown.
        m_start = xy(100, 200); m_dest = xy(300, 200);
        set_req(2, m_start, m_dest);
        push(K_GRANT, 2, -1, m_start, m_dest);
        push(K_HIT, 2, hit_k + 1, 0, 0);
        push(K_GRANT, 2, CD + 1, m_start, m_dest);
        push(K_HIT, 2, hit_k + 1, 0, 0);
        req_valid = 4'b0100;
        wait_grants(n_grants + 2, 200);
        req_valid = '0;
        drain(200);
        rr_ptr = 3;

        // All four requesting continuously: grants rotate from the pointer.
        repeat (25) @(posedge Clk);
        #2;
        for (int i = 0; i < int'(N); i++) set_req(i, m_start, m_dest);
        for (int k = 0; k < 5; k++) begin
            push(K_GRANT, rr_ptr, -1, m_start, m_dest);
            push(K_HIT, rr_ptr, hit_k + 1, 0, 0);
            rr_ptr = (rr_ptr + 1) % int'(N);
        end
        req_valid = '1;
        wait_grants(n_grants + 5, 300);
        req_valid = '0;
        drain(200);

        // Out-of-bounds dart.
        mode = M_OOB;
        push(K_GRANT, 1, -1, m_start, m_dest);
        push(K_MISS, 1, 5, 0, 0);
        req_valid = 4'b0010;
        wait_grants(n_grants + 1, 100);
        req_valid = '0;
        drain(200);

        // Frozen dart: timeout miss 50 cycles after launch.
        mode = M_FROZEN;
        push(K_GRANT, 0, -1, m_start, m_dest);
        push(K_MISS, 0, TO, 0, 0);
        req_valid = 4'b0001;
        wait_grants(n_grants + 1, 100);
        req_valid = '0;
        drain(200);

        // Lost dart: zero position ignored for two flight cycles, then miss.
        mode = M_LOST;
        push(K_GRANT, 3, -1, m_start, m_dest);
        push(K_MISS, 3, 4, 0, 0);
        req_valid = 4'b1000;
        wait_grants(n_grants + 1, 100);
        req_valid = '0;
        drain(200);

        // Invalid requests are never granted and do not block a valid one.
        mode = M_HIT;
        set_req(0, xy(100, 200), xy(700, 10));
        set_req(1, 20'd0, xy(300, 200));
        set_req(3, xy(300, 200), xy(300, 200));
        push(K_GRANT, 2, -1, m_start, m_dest);
        push(K_HIT, 2, hit_k + 1, 0, 0);
        req_valid = 4'b1111;
        wait_grants(n_grants + 1, 100);
        req_valid = 4'b1011;
        drain(200);
        repeat (30) @(posedge Clk);
        @(negedge Clk);
        check_val("idle_not_busy", busy, 0);

        // Reset in mid-flight abandons the dart silently.
        @(posedge Clk); #2;
        mode = M_FROZEN;
        push(K_GRANT, 2, -1, m_start, m_dest);
        req_valid = 4'b0100;
        wait_grants(n_grants + 1, 100);
        req_valid = '0;
        repeat (10) @(posedge Clk);
        #2;
        reset = 1'b1;
        @(negedge Clk);
        check_val("reset_midflight", {busy, hit, miss, dart_kill, monk_ready, grant}, 0);
        @(posedge Clk); #2;
        @(negedge Clk);
        check_val("reset_hold", {busy, hit, miss, dart_kill, active_id}, 0);
        @(posedge Clk); #2;
        reset = 1'b0;
        repeat (60) @(posedge Clk);
        @(negedge Clk);
        check_val("post_reset_idle", {busy, dart_start, dart_dest}, 0);
        check_val("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
